// File: rtl/seq_match_ctrl_if.sv
// Control/stream bus for the programmable sequence matcher.
// master: register/control side and serial source; slave: the matcher.
interface seq_match_ctrl_if #(
   parameter int MAXLEN = 8,
   parameter int CNT_W  = 8
);
   localparam int LEN_W = $clog2(MAXLEN + 1);

   logic              cfg_wr;
   logic [MAXLEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]  cfg_len;
   logic              cfg_overlap;
   logic [CNT_W-1:0]  cfg_thresh;
   logic              start;
   logic              stop;
   logic              in_valid;
   logic              in;
   logic              busy;
   logic              match;
   logic [CNT_W-1:0]  match_count;
   logic              thresh_hit;
   logic              cfg_err;

   modport master (
      output cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
      output start, stop, in_valid, in,
      input  busy, match, match_count, thresh_hit, cfg_err
   );

   modport slave (
      input  cfg_wr, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
      input  start, stop, in_valid, in,
      output busy, match, match_count, thresh_hit, cfg_err
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern-match controller: holds pattern/length/overlap/
// threshold config, runs IDLE/RUN/DONE, shifts gated bits into a window and
// reports registered match pulses, a saturating count and a sticky threshold flag.
module seq_match_ctrl #(
   parameter int MAXLEN = 8,
   parameter int CNT_W  = 8
) (
   input logic             clk,
   input logic             reset,
   seq_match_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(MAXLEN + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   logic [MAXLEN-1:0] pat_r;
   logic [LEN_W-1:0]  len_r;
   logic              ovl_r;
   logic [CNT_W-1:0]  thr_r;
   logic [MAXLEN-1:0] win;
   logic [LEN_W-1:0]  fill;
   logic              busy_r, match_r, th_r, err_r;
   logic [CNT_W-1:0]  count_r;

   logic [MAXLEN-1:0] win_next, len_mask;
   logic [LEN_W-1:0]  fill_next;
   logic [CNT_W-1:0]  cnt_next;
   logic              hit, cfg_ok;

   // Next window/fill if the current bit were shifted in, and whether that completes the pattern.
   always_comb begin
      win_next  = {win[MAXLEN-2:0], bus.in};
      fill_next = (fill == LEN_W'(MAXLEN)) ? fill : fill + LEN_W'(1);
      len_mask  = '0;
      for (int i = 0; i < MAXLEN; i++)
         len_mask[i] = (LEN_W'(i) < len_r);
      hit      = (fill_next >= len_r) && (((win_next ^ pat_r) & len_mask) == '0);
      cnt_next = (count_r == '1) ? count_r : count_r + CNT_W'(1);
      cfg_ok   = (state != RUN) && (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAXLEN));
   end

   // Config registers, run FSM, window and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pat_r   <= MAXLEN'(4'b1001);
         len_r   <= LEN_W'(4);
         ovl_r   <= 1'b1;
         thr_r   <= '0;
         win     <= '0;
         fill    <= '0;
         busy_r  <= 1'b0;
         match_r <= 1'b0;
         count_r <= '0;
         th_r    <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         match_r <= 1'b0;
         err_r   <= bus.cfg_wr && !cfg_ok;
         // Loads before the state update so a same-cycle start uses the new config.
         if (bus.cfg_wr && cfg_ok) begin
            pat_r <= bus.cfg_pattern;
            len_r <= bus.cfg_len;
            ovl_r <= bus.cfg_overlap;
            thr_r <= bus.cfg_thresh;
         end
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state   <= RUN;
                  busy_r  <= 1'b1;
                  win     <= '0;
                  fill    <= '0;
                  count_r <= '0;
                  th_r    <= 1'b0;
               end
            end
            RUN: begin
               // stop wins over a completing bit: that bit is dropped.
               if (bus.stop) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end else if (bus.in_valid) begin
                  win  <= win_next;
                  fill <= (hit && !ovl_r) ? '0 : fill_next;
                  if (hit) begin
                     match_r <= 1'b1;
                     count_r <= cnt_next;
                     if (thr_r != '0 && cnt_next == thr_r) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        th_r   <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_r;
   assign bus.match       = match_r;
   assign bus.match_count = count_r;
   assign bus.thresh_hit  = th_r;
   assign bus.cfg_err     = err_r;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed scenarios plus random traffic; a bit-history
// reference model pushes expected per-cycle outputs that a monitor pops and compares.
module tb_seq_match_ctrl;
   localparam int MAXLEN = 8;
   localparam int CNT_W  = 8;

   typedef struct {
      bit busy;
      bit match;
      int cnt;
      bit th;
      bit err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // cfg values presented on the next cfg_wr
   bit [7:0] cp;
   int       cl;
   bit       co;
   int       ct;

   // reference model state
   int       m_mode;   // 0 idle, 1 run, 2 done
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   int       m_thr;
   int       m_cnt;
   bit       m_th;
   bit       hist[$];

   seq_match_ctrl_if #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) bus ();

   seq_match_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp_v, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("busy", int'(bus.busy), int'(e.busy));
            chk("match", int'(bus.match), int'(e.match));
            chk("match_count", int'(bus.match_count), e.cnt);
            chk("thresh_hit", int'(bus.thresh_hit), int'(e.th));
            chk("cfg_err", int'(bus.cfg_err), int'(e.err));
         end
      end
   end

   function automatic bit tail_matches();
      if (hist.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++)
         if (hist[hist.size() - m_len + i] != m_pat[m_len-1-i]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive inputs at negedge, advance the model, queue the expected outputs.
   task automatic cyc(input bit r, input bit cw, input bit st, input bit sp,
                      input bit iv, input bit b);
      exp_t e;
      bit   rej;
      @(negedge clk);
      reset           = r;
      bus.cfg_wr      = cw;
      bus.cfg_pattern = cp;
      bus.cfg_len     = 4'(cl);
      bus.cfg_overlap = co;
      bus.cfg_thresh  = 8'(ct);
      bus.start       = st;
      bus.stop        = sp;
      bus.in_valid    = iv;
      bus.in          = b;
      e.match = 1'b0;
      e.err   = 1'b0;
      if (r) begin
         m_mode = 0; m_pat = 8'b1001; m_len = 4; m_ovl = 1'b1; m_thr = 0;
         m_cnt = 0; m_th = 1'b0; hist.delete();
      end else begin
         rej   = (m_mode == 1) || (cl < 1) || (cl > MAXLEN);
         e.err = cw && rej;
         if (cw && !rej) begin
            m_pat = cp; m_len = cl; m_ovl = co; m_thr = ct;
         end
         if (m_mode != 1) begin
            if (st) begin
               m_mode = 1; m_cnt = 0; m_th = 1'b0; hist.delete();
            end
         end else if (sp) begin
            m_mode = 0;
         end else if (iv) begin
            hist.push_back(b);
            if (hist.size() > MAXLEN) void'(hist.pop_front());
            if (tail_matches()) begin
               e.match = 1'b1;
               m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
               if (!m_ovl) hist.delete();
               if (m_thr != 0 && m_cnt == m_thr) begin
                  m_th = 1'b1; m_mode = 2;
               end
            end
         end
      end
      e.busy = (m_mode == 1);
      e.cnt  = m_cnt;
      e.th   = m_th;
      q.push_back(e);
   endtask

   task automatic bits(input bit [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(0, 0, 0, 0, 1, v[i]);
   endtask

   task automatic set_cfg(input bit [7:0] p, input int l, input bit o, input int t);
      cp = p; cl = l; co = o; ct = t;
   endtask

   initial begin
      reset = 1'b1;
      bus.cfg_wr = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
      bus.cfg_thresh = 0; bus.start = 0; bus.stop = 0; bus.in_valid = 0; bus.in = 0;
      set_cfg(8'b1001, 4, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);                 // stop in IDLE ignored

      // default config, overlapping
      cyc(0, 0, 1, 0, 0, 0);
      bits(16'b1001001, 7);
      cyc(0, 0, 1, 0, 0, 0);                 // start in RUN ignored
      cyc(0, 0, 0, 1, 0, 0);

      // non-overlap, cfg_wr together with start
      set_cfg(8'b1001, 4, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      bits(16'b1001001, 7);
      cyc(0, 0, 0, 1, 0, 0);

      // threshold 2: DONE after 7th bit, trailing bits ignored, restart clears
      set_cfg(8'b1001, 4, 1, 2);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      bits(16'b1001001001, 10);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);

      // rejected writes: len 0, len 9, any write in RUN
      set_cfg(8'b1001, 4, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);
      set_cfg(8'b11, 0, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);
      set_cfg(8'b11, 9, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      set_cfg(8'b11, 2, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);
      bits(16'b1001, 4);
      cyc(0, 0, 0, 1, 0, 0);

      // pattern 11 len 2 with gaps; stop with a completing bit drops it
      cyc(0, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 1, 1, 1);
      cyc(0, 0, 0, 0, 0, 0);

      // reset mid-run, then window is clear
      cyc(0, 0, 1, 0, 0, 0);
      bits(16'b100, 3);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0);

      // randomized traffic with short patterns so matches are frequent
      for (int k = 0; k < 600; k++) begin
         bit cw;
         cw = ($urandom_range(15) == 0);
         if (cw) set_cfg(8'($urandom), $urandom_range(9) < 8 ? $urandom_range(1, 4)
                                                          : $urandom_range(0, 9),
                         1'($urandom_range(1)), $urandom_range(0, 4));
         cyc($urandom_range(149) == 0, cw, $urandom_range(7) == 0,
             $urandom_range(39) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)));
      end

      cyc(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial pattern-match controller for the sequence detector family. It holds a run-time configuration: pattern, length 1..MAXLEN, overlap mode and a match-count threshold. It sequences a detection run from start to stop or threshold, scans a gated serial bitstream, and reports registered match pulses, a saturating match count and a threshold-reached flag. It sits between the register/control interface and the serial input, and replaces per-pattern hard-coded Mealy/Moore detectors.

## Interface
- MAXLEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, width of match counter and threshold
- LEN_W, $clog2(MAXLEN+1), width of length field (derived, not overridden)

- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- cfg_wr  input  1  configuration write strobe
- cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the first bit expected on the stream
- cfg_len  input  LEN_W  pattern length; legal 1..MAXLEN
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- cfg_thresh  input  CNT_W  stop after this many matches; 0 = no threshold
- start  input  1  begin a run (IDLE/DONE only)
- stop  input  1  abort a run (RUN only)
- in_valid  input  1  qualifies in for this cycle
- in  input  1  serial data bit
- busy  output  1  high in RUN
- match  output  1  one-cycle registered match pulse
- match_count  output  CNT_W  matches in current run, saturating
- thresh_hit  output  1  threshold reached; sticky until next start or reset
- cfg_err  output  1  one-cycle pulse on a rejected cfg_wr

## Operation
- Config registers reset to pattern = 'b1001 (zero-extended), len = 4, overlap = 1, thresh = 0.
- cfg_wr is accepted in IDLE or DONE when 1 ≤ cfg_len ≤ MAXLEN. All four fields load atomically.
- cfg_wr with an illegal cfg_len, or in any state during RUN, is rejected. Configuration is unchanged and cfg_err pulses.
- FSM states: IDLE, RUN, DONE. Reset goes to IDLE.
- IDLE: start goes to RUN. stop is ignored.
- RUN:
  - stop goes to IDLE. stop has priority over in_valid and threshold in the same cycle; that bit is discarded and match stays 0.
  - start is ignored.
- RUN to DONE: on the edge where match_count becomes equal to a nonzero thresh.
- DONE: in_valid is ignored. start goes to RUN.
- Entering RUN clears the window, fill counter, match_count and thresh_hit.
- Window operation:
  - On in_valid in RUN: win <= {win[MAXLEN-2:0], in} and fill <= min(fill+1, MAXLEN).
  - Match when fill_next ≥ len and win_next[len-1:0] == pattern[len-1:0].
- On a match:
  - match <= 1 and match_count increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: fill resets to 0, so the next match needs len fresh bits.
  - Overlap mode: fill is retained.
- Bits with in_valid low are not shifted and do not break a partial match (gaps are transparent).
- Reset values:
  - All outputs are 0 (busy, match, match_count, thresh_hit, cfg_err).
  - win and fill are 0.
- Reset mid-run returns to IDLE immediately and restores the default configuration.

## Timing
- Match latency: match is high in the cycle after the edge that sampled the completing bit. It lasts exactly one cycle unless the next valid bit also completes a match.
- match_count updates on the same edge as match. thresh_hit and the DONE state follow on that same edge.
- busy rises on the edge sampling start and falls on the edge sampling stop, or on the threshold edge.
- cfg_err is asserted for the cycle after the rejected cfg_wr.
- Back-to-back in_valid is supported at full rate, one bit per clock.
- start plus cfg_wr in the same IDLE cycle: the config loads and the run uses the new config.

## Test plan
- Default config (1001, overlap), stream 1,0,0,1,0,0,1 one bit per clock -> match pulses after the 4th and 7th bits; match_count = 2; busy stays 1.
- cfg_overlap = 0, same stream -> single match after the 4th bit; match_count = 1.
- cfg_thresh = 2, overlap, stream 1001001 then 001 -> thresh_hit = 1 and busy = 0 after the 7th bit; trailing bits ignored, match_count holds 2; start clears the count to 0 and thresh_hit to 0.
- cfg_wr with cfg_len = 0, then with cfg_len = 9 (MAXLEN = 8), then any cfg_wr during RUN -> cfg_err pulses each time, config unchanged (pattern 1001 still detected).
- Pattern 11 with len 2, in_valid gapped 1,–,1,–,1 -> matches after the 2nd and 3rd valid bits; stop asserted with in_valid and in = 1 completing a match -> no match, state IDLE, count unchanged.
- reset asserted mid-RUN after 3 bits of 1001 -> next cycle all outputs 0, IDLE; start then 1 -> no match (window cleared).
